// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer shared by the MEM-stage CPU port and a DMA/debug port.
// Optional DMEM_ARB_RR_EN selects round-robin arbitration (default: CPU fixed priority).
module dmem_access_ctrl #(
  parameter int AW          = 7,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q;
  logic          acc_we_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  logic          cpu_req;
  logic          grant_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          resp_cpu, resp_dma;

  assign cpu_req = cpu_read | cpu_write;

`ifdef DMEM_ARB_RR_EN
  owner_t last_grant_q;
  // On a tie the port that did not win last time takes the memory.
  assign grant_dma = dma_req & (!cpu_req | (last_grant_q == OWN_CPU));
`else
  assign grant_dma = dma_req & !cpu_req;
`endif

  // A simultaneous load and store from the pipeline is treated as a load.
  assign sel_we    = grant_dma ? dma_we    : (cpu_write & !cpu_read);
  assign sel_addr  = grant_dma ? dma_addr  : cpu_addr;
  assign sel_wdata = grant_dma ? dma_wdata : cpu_wdata;

  assign resp_cpu = (state_q == RESP) && (owner_q == OWN_CPU);
  assign resp_dma = (state_q == RESP) && (owner_q == OWN_DMA);

  assign cpu_stall = cpu_req & !resp_cpu;

  // Read data is forwarded straight from memory during RESP so the requester
  // sees it in that cycle; the holding registers keep it afterwards.
  assign cpu_rdata = (resp_cpu && !acc_we_q) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (resp_dma && !acc_we_q) ? mem_rdata : dma_rdata_q;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req || dma_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0)        state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      acc_we_q    <= 1'b0;
      cnt_q       <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      dma_done    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= OWN_DMA;
`endif
    end else begin
      state_q  <= state_d;
      dma_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner_q   <= grant_dma ? OWN_DMA : OWN_CPU;
            acc_we_q  <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt_q     <= WAIT_STATES[3:0];
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= grant_dma ? OWN_DMA : OWN_CPU;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            // Registered so the pulse lines up with the RESP cycle.
            dma_done <= (owner_q == OWN_DMA);
          end
        end
        RESP: begin
          if (!acc_we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            else                    dma_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: one instance with WAIT_STATES=0 and one with
// WAIT_STATES=2, each backed by a synchronous-read memory model; inputs are shared.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [6:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [6:0]  dma_addr = '0;
  logic [31:0] dma_wdata = '0;

  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_done, mem_en, mem_we;
  logic [6:0]  mem_addr;

  logic [31:0] w2_cpu_rdata, w2_dma_rdata, w2_mem_wdata, w2_mem_rdata;
  logic        w2_cpu_stall, w2_dma_done, w2_mem_en, w2_mem_we;
  logic [6:0]  w2_mem_addr;

  logic [31:0] mem0 [128];
  logic [31:0] mem2 [128];

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  bit mon_t2 = 1'b0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.AW(7), .DW(32), .WAIT_STATES(0)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_access_ctrl #(.AW(7), .DW(32), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(w2_cpu_rdata), .cpu_stall(w2_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(w2_dma_rdata), .dma_done(w2_dma_done),
    .mem_en(w2_mem_en), .mem_we(w2_mem_we), .mem_addr(w2_mem_addr), .mem_wdata(w2_mem_wdata),
    .mem_rdata(w2_mem_rdata)
  );

  // Synchronous memories: read data appears the cycle after the enable cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem0[mem_addr] = mem_wdata;
      else        mem_rdata <= mem0[mem_addr];
    end
    if (w2_mem_en) begin
      if (w2_mem_we) mem2[w2_mem_addr] = w2_mem_wdata;
      else           w2_mem_rdata <= mem2[w2_mem_addr];
    end
  end

  always @(negedge clk) if (mon_t2 && dma_done) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [4:0] en_exp;
    logic [4:0] stall_exp;

    for (int i = 0; i < 128; i++) begin
      mem0[i] = '0;
      mem2[i] = '0;
    end
    mem0[42] = 32'd123;
    mem0[50] = 32'd321;
    mem2[42] = 32'd123;
    mem_rdata = '0;
    w2_mem_rdata = '0;

    // Reset state
    do_reset();
    sample();
    check("rst_mem_en",    mem_en,    0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_dma_done",  dma_done,  0);
    check("rst_stall",     cpu_stall, 0);

    // WAIT_STATES=2 read: enable 3 cycles, stall 4, data in the 5th
    en_exp    = 5'b01110;
    stall_exp = 5'b01111;
    step();
    cpu_read = 1'b1;
    cpu_addr = 7'd42;
    for (int i = 0; i < 5; i++) begin
      sample();
      check($sformatf("ws2_en_c%0d", i),    w2_mem_en,    en_exp[i]);
      check($sformatf("ws2_stall_c%0d", i), w2_cpu_stall, stall_exp[i]);
      if (i == 4) check("ws2_rdata", w2_cpu_rdata, 32'd123);
      step();
    end
    cpu_read = 1'b0;
    repeat (8) step();

    // Single CPU read, zero wait states
    do_reset();
    step();
    cpu_read = 1'b1;
    cpu_addr = 7'd42;
    sample();
    check("rd_T_stall",  cpu_stall, 1);
    check("rd_T_en",     mem_en,    0);
    step();
    sample();
    check("rd_T1_stall", cpu_stall, 1);
    check("rd_T1_en",    mem_en,    1);
    check("rd_T1_addr",  mem_addr,  42);
    check("rd_T1_we",    mem_we,    0);
    step();
    sample();
    check("rd_T2_stall", cpu_stall, 0);
    check("rd_T2_en",    mem_en,    0);
    check("rd_T2_rdata", cpu_rdata, 123);
    step();
    cpu_read = 1'b0;
    sample();
    check("rd_T3_rdata_held", cpu_rdata, 123);
    check("rd_T3_stall", cpu_stall, 0);
    repeat (8) step();

`ifdef DMEM_ARB_RR_EN
    // Round-robin: both ports request continuously
    do_reset();
    step();
    cpu_read = 1'b1;
    cpu_addr = 7'd42;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 7'd50;
    for (int k = 0; k < 4; k++) begin
      step();
      sample();
      check($sformatf("rr_en_%0d", k),    mem_en,   1);
      check($sformatf("rr_grant_%0d", k), mem_addr, (k % 2 == 1) ? 32'd50 : 32'd42);
      step();
      step();
    end
    cpu_read = 1'b0;
    dma_req  = 1'b0;
    repeat (8) step();
`else
    // Fixed priority: CPU first, DMA served after
    step();
    cpu_read = 1'b1;
    cpu_addr = 7'd42;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 7'd50;
    step();
    sample();
    check("fp_T1_addr", mem_addr, 42);
    step();
    sample();
    check("fp_T2_cpu_rdata", cpu_rdata, 123);
    check("fp_T2_done",      dma_done,  0);
    step();
    cpu_read = 1'b0;
    step();
    sample();
    check("fp_T4_en",   mem_en,   1);
    check("fp_T4_addr", mem_addr, 50);
    step();
    sample();
    check("fp_T5_done",  dma_done,  1);
    check("fp_T5_rdata", dma_rdata, 321);
    step();
    dma_req = 1'b0;
    sample();
    check("fp_T6_done",       dma_done,  0);
    check("fp_T6_rdata_held", dma_rdata, 321);
    repeat (8) step();
`endif

    // Reset during a DMA write access aborts it
    step();
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 7'd60;
    dma_wdata = 32'h55;
    step();
    sample();
    check("rst6_pre_en", mem_en, 1);
    check("rst6_pre_we", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("rst6_en_drop", mem_en,   0);
    check("rst6_no_done", dma_done, 0);
    step();
    dma_req = 1'b0;
    dma_we  = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("rst6_idle_done_%0d", i), dma_done, 0);
      check($sformatf("rst6_idle_en_%0d", i),   mem_en,   0);
      step();
    end
    check("rst6_mem_untouched", mem0[60], 0);
    dma_req  = 1'b1;
    dma_addr = 7'd42;
    step();
    step();
    sample();
    check("rst6_next_done",  dma_done,  1);
    check("rst6_next_rdata", dma_rdata, 123);
    step();
    dma_req = 1'b0;
    repeat (4) step();

    // CPU store then load; a load+store together is a load
    mon_t2    = 1'b1;
    cpu_write = 1'b1;
    cpu_addr  = 7'd50;
    cpu_wdata = 32'hDEAD;
    step();
    sample();
    check("wr_T1_en",    mem_en,    1);
    check("wr_T1_we",    mem_we,    1);
    check("wr_T1_addr",  mem_addr,  50);
    check("wr_T1_wdata", mem_wdata, 32'hDEAD);
    step();
    sample();
    check("wr_T2_stall", cpu_stall, 0);
    check("wr_T2_rdata_unchanged", cpu_rdata, 0);
    step();
    cpu_read  = 1'b1;
    cpu_wdata = 32'hBEEF;
    step();
    sample();
    check("rw_T1_en", mem_en, 1);
    check("rw_T1_we", mem_we, 0);
    step();
    sample();
    check("rw_T2_rdata", cpu_rdata, 32'hDEAD);
    check("rw_T2_stall", cpu_stall, 0);
    step();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    repeat (4) step();
    mon_t2 = 1'b0;
    check("wr_mem_kept",   mem0[50],  32'hDEAD);
    check("wr_no_dma_done", done_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
